pc_fetch_unit: RTL and testbench

- Program-counter and fetch-sequencing stage directly upstream of the CPU control unit.
- Holds the PC and drives the instruction-memory address; the fetched word's opcode field feeds the control unit.
- Consumes the control unit's jump/beq outputs and the ALU zero flag to select the next PC.
- Stalls on instruction-memory busywait and keeps a count of retired instructions.

---
 rtl/pc_fetch_unit.sv | 74 +++++++
 tb/tb_pc_fetch_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer feeding the control unit; PC advances one edge after a retiring cycle.
// INSTR_VALID/OPCODE are combinational; instruction-memory BUSYWAIT stalls PC and retire count in place.
module pc_fetch_unit #(
   parameter int                  PC_WIDTH     = 32,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
   parameter int                  CNT_WIDTH    = 16
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 JUMP,
   input  logic                 BEQ,
   input  logic                 ZERO,
   input  logic [7:0]           OFFSET,
   input  logic                 BUSYWAIT,
   input  logic [31:0]          INSTRUCTION,
   output logic [PC_WIDTH-1:0]  PC,
   output logic [7:0]           OPCODE,
   output logic                 INSTR_VALID,
   output logic [CNT_WIDTH-1:0] RETIRED
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2
   } state_t;

   localparam logic [PC_WIDTH-1:0] RESET_PC = {RESET_VECTOR[PC_WIDTH-1:2], 2'b00};

   state_t              state;
   logic [PC_WIDTH-1:0] pc_plus4;
   logic [PC_WIDTH-1:0] offset_bytes;
   logic [PC_WIDTH-1:0] target;
   logic [PC_WIDTH-1:0] next_pc;
   logic                take_target;
   logic                retire;
   logic                unused_instr_bits;

   // OFFSET counts words: sign-extend and scale to bytes.
   assign pc_plus4     = PC + PC_WIDTH'(4);
   assign offset_bytes = {{(PC_WIDTH-10){OFFSET[7]}}, OFFSET, 2'b00};
   assign target       = pc_plus4 + offset_bytes;
   assign take_target  = JUMP | (BEQ & ZERO);
   assign next_pc      = take_target ? target : pc_plus4;

   assign retire            = (state == RUN) & ~BUSYWAIT;
   assign INSTR_VALID       = retire;
   assign OPCODE            = INSTR_VALID ? INSTRUCTION[31:24] : 8'h00;
   assign unused_instr_bits = ^INSTRUCTION[23:0];

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         PC      <= RESET_PC;
         RETIRED <= '0;
         state   <= BOOT;
      end else begin
         case (state)
            BOOT:  state <= BUSYWAIT ? STALL : RUN;
            RUN: begin
               if (BUSYWAIT) begin
                  state <= STALL;
               end else begin
                  PC      <= next_pc;
                  RETIRED <= RETIRED + CNT_WIDTH'(1);
               end
            end
            // Leaving STALL re-presents the held instruction before advancing.
            STALL: if (!BUSYWAIT) state <= RUN;
            default: state <= BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: a default instance plus a narrow-counter, high-reset-vector instance on shared inputs.
module tb_pc_fetch_unit;

   localparam int S_BOOT  = 0;
   localparam int S_RUN   = 1;
   localparam int S_STALL = 2;

   typedef struct {
      logic [31:0] pc;
      logic [15:0] ret;
      logic [31:0] pc2;
      logic [3:0]  ret2;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, jump, beq, zero, busywait;
   logic [7:0]  offset;
   logic [31:0] instruction;

   logic [31:0] pc, pc2;
   logic [7:0]  opcode, opcode2;
   logic        instr_valid, instr_valid2;
   logic [15:0] retired;
   logic [3:0]  retired2;

   int          n_checks = 0;
   int          n_fail   = 0;

   logic [31:0] m_pc[2];
   int          m_ret[2];
   int          m_st[2];
   logic [31:0] rv[2]      = '{32'h0000_0000, 32'hFFFF_FFF0};
   int          ret_mod[2] = '{65536, 16};
   exp_t        exp_q[$];
   exp_t        e;

   pc_fetch_unit u_dut (
      .CLK(clk), .RESET(reset), .JUMP(jump), .BEQ(beq), .ZERO(zero), .OFFSET(offset),
      .BUSYWAIT(busywait), .INSTRUCTION(instruction), .PC(pc), .OPCODE(opcode),
      .INSTR_VALID(instr_valid), .RETIRED(retired)
   );

   pc_fetch_unit #(.PC_WIDTH(32), .RESET_VECTOR(32'hFFFF_FFF0), .CNT_WIDTH(4)) u_dut2 (
      .CLK(clk), .RESET(reset), .JUMP(jump), .BEQ(beq), .ZERO(zero), .OFFSET(offset),
      .BUSYWAIT(busywait), .INSTRUCTION(instruction), .PC(pc2), .OPCODE(opcode2),
      .INSTR_VALID(instr_valid2), .RETIRED(retired2)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] calc_next(logic [31:0] cur);
      int o;
      o = $signed(offset);
      if (jump || (beq && zero)) return cur + 32'd4 + 32'(o * 4);
      return cur + 32'd4;
   endfunction

   // Advance the reference model with the inputs as they stand, queue the expectation, cross one edge.
   task automatic step();
      exp_t x;
      for (int i = 0; i < 2; i++) begin
         if (!reset) begin
            m_pc[i] = rv[i]; m_ret[i] = 0; m_st[i] = S_BOOT;
         end else if (m_st[i] == S_BOOT) begin
            m_st[i] = busywait ? S_STALL : S_RUN;
         end else if (m_st[i] == S_RUN) begin
            if (busywait) m_st[i] = S_STALL;
            else begin
               m_pc[i]  = calc_next(m_pc[i]);
               m_ret[i] = (m_ret[i] + 1) % ret_mod[i];
            end
         end else if (!busywait) begin
            m_st[i] = S_RUN;
         end
      end
      x.pc = m_pc[0]; x.ret = 16'(m_ret[0]); x.pc2 = m_pc[1]; x.ret2 = 4'(m_ret[1]);
      exp_q.push_back(x);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0; jump = 0; beq = 0; zero = 0; busywait = 0; offset = 8'h00;
      instruction = 32'hAB12_3456;
      step(); e = exp_q.pop_front();
      step(); e = exp_q.pop_front();
      n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
      n_checks++; if (retired !== 16'h0) begin n_fail++; $display("FAIL reset_ret: got %h want 0", retired); end
      n_checks++; if (instr_valid !== 1'b0 || opcode !== 8'h00) begin n_fail++; $display("FAIL reset_vld: vld=%b op=%h want 0/00", instr_valid, opcode); end
      n_checks++; if (pc2 !== 32'hFFFF_FFF0 || pc2 !== e.pc2) begin n_fail++; $display("FAIL reset_vector: got %h want %h", pc2, 32'hFFFF_FFF0); end
   endtask

   task automatic test_sequential();
      reset = 1'b1;
      #1;
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL boot_vld: got %b want 0", instr_valid); end
      step(); e = exp_q.pop_front();
      n_checks++; if (pc !== e.pc || pc !== 32'h0) begin n_fail++; $display("FAIL boot_pc: got %h want %h", pc, e.pc); end
      n_checks++; if (instr_valid !== 1'b1 || opcode !== 8'hAB) begin n_fail++; $display("FAIL run_opcode: vld=%b op=%h want 1/ab", instr_valid, opcode); end
      repeat (3) begin
         step(); e = exp_q.pop_front();
         n_checks++; if (pc !== e.pc || retired !== e.ret) begin n_fail++; $display("FAIL seq_step: pc=%h ret=%0d want %h/%0d", pc, retired, e.pc, e.ret); end
      end
      n_checks++; if (pc !== 32'h0C || retired !== 16'd3) begin n_fail++; $display("FAIL seq_end: pc=%h ret=%0d want 0c/3", pc, retired); end
   endtask

   task automatic test_branch();
      step(); e = exp_q.pop_front();
      n_checks++; if (pc !== 32'h10) begin n_fail++; $display("FAIL br_setup: got %h want 10", pc); end
      beq = 1; zero = 1; offset = 8'hFE;
      step(); e = exp_q.pop_front();
      n_checks++; if (pc !== 32'h0C || pc !== e.pc) begin n_fail++; $display("FAIL beq_taken: got %h want 0c", pc); end
      beq = 0; zero = 0;
      step(); e = exp_q.pop_front();
      beq = 1; zero = 0; offset = 8'hFE;
      step(); e = exp_q.pop_front();
      n_checks++; if (pc !== 32'h14 || pc !== e.pc) begin n_fail++; $display("FAIL beq_not_taken: got %h want 14", pc); end
      beq = 0;
   endtask

   task automatic test_jump();
      jump = 1; offset = 8'hFE;
      step(); e = exp_q.pop_front();
      n_checks++; if (pc !== 32'h10) begin n_fail++; $display("FAIL jmp_back: got %h want 10", pc); end
      offset = 8'h7F;
      step(); e = exp_q.pop_front();
      n_checks++; if (pc !== 32'h210 || pc !== e.pc) begin n_fail++; $display("FAIL jmp_fwd_max: got %h want 210", pc); end
      offset = 8'h80;
      step(); e = exp_q.pop_front();
      n_checks++; if (pc !== 32'h14) begin n_fail++; $display("FAIL jmp_neg_max: got %h want 14", pc); end
      offset = 8'hFE;
      step(); e = exp_q.pop_front();
      beq = 1; zero = 0; offset = 8'h02;
      step(); e = exp_q.pop_front();
      n_checks++; if (pc !== 32'h1C || pc !== e.pc) begin n_fail++; $display("FAIL jmp_priority: got %h want 1c", pc); end
      beq = 0; offset = 8'hFA;
      step(); e = exp_q.pop_front();
      n_checks++; if (pc !== 32'h08 || retired !== e.ret || pc2 !== e.pc2) begin n_fail++; $display("FAIL jmp_to_08: pc=%h ret=%0d want 08/%0d", pc, retired, e.ret); end
      jump = 0;
   endtask

   task automatic test_stall();
      busywait = 1; instruction = 32'hC300_0000;
      #1;
      n_checks++; if (instr_valid !== 1'b0 || opcode !== 8'h00) begin n_fail++; $display("FAIL busy_comb: vld=%b op=%h want 0/00", instr_valid, opcode); end
      jump = 1; offset = 8'h7F;
      repeat (3) begin
         step(); e = exp_q.pop_front();
         n_checks++; if (pc !== 32'h08 || retired !== e.ret || retired !== 16'd13) begin n_fail++; $display("FAIL stall_hold: pc=%h ret=%0d want 08/13", pc, retired); end
         n_checks++; if (instr_valid !== 1'b0 || opcode !== 8'h00) begin n_fail++; $display("FAIL stall_vld: vld=%b op=%h want 0/00", instr_valid, opcode); end
      end
      busywait = 0; jump = 0;
      #1;
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release_vld: got %b want 0", instr_valid); end
      step(); e = exp_q.pop_front();
      n_checks++; if (pc !== 32'h08 || instr_valid !== 1'b1 || opcode !== 8'hC3) begin n_fail++; $display("FAIL represent: pc=%h vld=%b op=%h want 08/1/c3", pc, instr_valid, opcode); end
      step(); e = exp_q.pop_front();
      n_checks++; if (pc !== 32'h0C || retired !== e.ret) begin n_fail++; $display("FAIL after_stall: pc=%h ret=%0d want 0c/%0d", pc, retired, e.ret); end
   endtask

   task automatic test_wrap();
      jump = 1; offset = 8'hFC;
      step(); e = exp_q.pop_front();
      n_checks++; if (pc !== 32'h0 || retired2 !== 4'hF || retired2 !== e.ret2) begin n_fail++; $display("FAIL wrap_setup: pc=%h ret2=%h want 0/f", pc, retired2); end
      offset = 8'hFE;
      step(); e = exp_q.pop_front();
      n_checks++; if (pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL pc_underflow: got %h want fffffffc", pc); end
      n_checks++; if (retired2 !== 4'h0 || retired !== 16'd16) begin n_fail++; $display("FAIL ret_wrap: ret2=%h ret=%0d want 0/16", retired2, retired); end
      jump = 0;
      step(); e = exp_q.pop_front();
      n_checks++; if (pc !== 32'h0 || pc2 !== e.pc2 || retired2 !== e.ret2) begin n_fail++; $display("FAIL pc_overflow: pc=%h pc2=%h want 0/%h", pc, pc2, e.pc2); end
   endtask

   task automatic test_reset_mid();
      busywait = 1;
      step(); e = exp_q.pop_front();
      jump = 1; offset = 8'h10; reset = 0;
      step(); e = exp_q.pop_front();
      n_checks++; if (pc !== 32'h0 || retired !== 16'h0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall: pc=%h ret=%0d vld=%b want 0/0/0", pc, retired, instr_valid); end
      n_checks++; if (pc2 !== 32'hFFFF_FFF0 || retired2 !== 4'h0) begin n_fail++; $display("FAIL rst_mid_stall2: pc2=%h ret2=%h want fffffff0/0", pc2, retired2); end
      reset = 1; busywait = 0;
      #1;
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_boot_vld: got %b want 0", instr_valid); end
      step(); e = exp_q.pop_front();
      n_checks++; if (pc !== 32'h0 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL boot_ignores_jump: pc=%h vld=%b want 0/1", pc, instr_valid); end
      step(); e = exp_q.pop_front();
      n_checks++; if (pc !== 32'h44 || pc !== e.pc) begin n_fail++; $display("FAIL jump_after_rst: got %h want 44", pc); end
      reset = 0;
      step(); e = exp_q.pop_front();
      n_checks++; if (pc !== 32'h0 || retired !== 16'h0) begin n_fail++; $display("FAIL rst_mid_jump: pc=%h ret=%0d want 0/0", pc, retired); end
      reset = 1; jump = 0;
      step(); e = exp_q.pop_front();
   endtask

   task automatic test_reset_glitch();
      step(); e = exp_q.pop_front();
      reset = 0;
      #2;
      n_checks++; if (pc !== 32'h04 || retired !== 16'd1) begin n_fail++; $display("FAIL glitch_async: pc=%h ret=%0d want 04/1", pc, retired); end
      reset = 1;
      step(); e = exp_q.pop_front();
      n_checks++; if (pc !== 32'h08 || retired !== 16'd2 || pc !== e.pc) begin n_fail++; $display("FAIL glitch_ignored: pc=%h ret=%0d want 08/2", pc, retired); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_sequential();
      test_branch();
      test_jump();
      test_stall();
      test_wrap();
      test_reset_mid();
      test_reset_glitch();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
